dx_iobuf_reg: RTL

DX_IOBUF_REG -- requirements
Module: dx_iobuf_reg

---
 rtl/dx_iobuf_reg.sv | 113 +++++++++++
 1 files changed

// File: rtl/dx_iobuf_reg.sv
// Registered bidirectional I/O buffer. Each bit has a direction FSM with turnaround
// delay, a registered output, an input synchroniser and a glitch filter with edge pulses.
module dx_iobuf_reg #(
    parameter int unsigned DATA_WIDTH  = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 1,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] dio_t,
    input  logic [DATA_WIDTH-1:0] dio_o,
    output logic [DATA_WIDTH-1:0] dio_i,
    output logic [DATA_WIDTH-1:0] dio_rise,
    output logic [DATA_WIDTH-1:0] dio_fall,
    output logic [DATA_WIDTH-1:0] dio_oe,
    inout  wire  [DATA_WIDTH-1:0] dio_p
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);
    localparam logic [3:0] TLAST = 4'(TURN_CYCLES > 0 ? TURN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IN,
        ST_TURN,
        ST_OUT
    } dir_state_t;

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_bit
        dir_state_t              state;
        logic [3:0]              tcnt;
        logic                    out_q;
        logic [SYNC_STAGES-1:0]  sync;
        logic                    s;
        logic [FW-1:0]           fcnt;
        logic                    in_q;
        logic                    rise_q;
        logic                    fall_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= ST_IN;
                tcnt  <= '0;
                out_q <= 1'b0;
            end else begin
                out_q <= dio_o[g];
                case (state)
                    ST_IN: begin
                        if (!dio_t[g]) begin
                            tcnt  <= '0;
                            state <= (TURN_CYCLES == 0) ? ST_OUT : ST_TURN;
                        end
                    end
                    ST_TURN: begin
                        // Any release request aborts the turnaround before the pin is driven.
                        if (dio_t[g])
                            state <= ST_IN;
                        else if (tcnt == TLAST)
                            state <= ST_OUT;
                        else
                            tcnt <= tcnt + 4'd1;
                    end
                    ST_OUT: begin
                        if (dio_t[g])
                            state <= ST_IN;
                    end
                    default: state <= ST_IN;
                endcase
            end
        end

        assign dio_oe[g] = (state == ST_OUT);
        assign dio_p[g]  = dio_oe[g] ? out_q : 1'bz;

        // The pad is sampled in every direction state so a driven value loops back.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                sync <= '0;
            else
                sync <= {sync[SYNC_STAGES-2:0], dio_p[g]};
        end

        assign s = sync[SYNC_STAGES-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                fcnt   <= '0;
                in_q   <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (s == in_q) begin
                    fcnt <= '0;
                end else if (fcnt == FLAST) begin
                    fcnt   <= '0;
                    in_q   <= s;
                    rise_q <= s;
                    fall_q <= ~s;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end

        assign dio_i[g]    = in_q;
        assign dio_rise[g] = rise_q;
        assign dio_fall[g] = fall_q;
    end

endmodule
